pulse_edge_gen: RTL and testbench

Converts single-cycle event pulses into clean level waveforms: each accepted pulse produces one rising edge and a fixed-width high phase on `dout`, followed by a guaranteed low gap. It is the transmit-side counterpart of our rising-edge detectors. Every event queued here reappears downstream as exactly one distinct rising edge. Pulses arriving while a waveform is in progress are counted and replayed back-to-back. Overflow is flagged.

---
 rtl/pulse_edge_gen.sv | 78 +++++++
 tb/tb_pulse_edge_gen.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pulse_edge_gen.sv
// pulse_edge_gen: turns single-cycle event pulses into fixed-width high pulses
// separated by a guaranteed low gap, queuing events that arrive mid-waveform.
module pulse_edge_gen #(
    parameter int HIGH_CYCLES = 3,
    parameter int LOW_CYCLES  = 2,
    parameter int PEND_W      = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pulse_in,
    input  logic              ovf_clr,
    output logic              dout,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);
    localparam int PH_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int CW = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [CW-1:0] PH_HIGH = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] PH_LOW = CW'(LOW_CYCLES - 1);
    localparam logic [CW-1:0] PH_ONE = CW'(1);
    localparam logic [PEND_W-1:0] P_ONE = PEND_W'(1);
    localparam logic [PEND_W-1:0] P_MAX = '1;

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     ph_q, ph_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d, dout_q, busy_q;
    logic              last, start, drop;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        last    = ph_q == '0;
        start   = (state_q == IDLE || (state_q == GAP && last)) && (pend_q != '0 || pulse_in);
        drop    = !start && pulse_in && pend_q == P_MAX;
        // phase counter counts down to zero; zero marks the last cycle of a phase
        if (start) begin
            state_d = HIGH;
            ph_d    = PH_HIGH;
        end else if (state_q == HIGH && last) begin
            state_d = GAP;
            ph_d    = PH_LOW;
        end else if (state_q == GAP && last) begin
            state_d = IDLE;
        end else if (state_q != IDLE) begin
            ph_d = ph_q - PH_ONE;
        end
        pend_d = start ? (pulse_in ? pend_q : pend_q - P_ONE)
                       : ((pulse_in && !drop) ? pend_q + P_ONE : pend_q);
        ovf_d  = drop | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            ph_q    <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            dout_q  <= state_d == HIGH;
            busy_q  <= state_d != IDLE;
        end
    end

    assign dout    = dout_q;
    assign busy    = busy_q;
    assign pending = pend_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_pulse_edge_gen.sv
// tb_pulse_edge_gen: directed and random stimulus checked against a timestamp-based
// event model (last start time plus a queued-event count).
module tb_pulse_edge_gen;
    localparam int H = 3;
    localparam int L = 2;
    localparam int PW = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          pulse_in = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          dout, busy, ovf;
    logic [PW-1:0] pending;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ls = -1000;
    int q = 0;
    int ov = 0;
    int rises = 0;
    logic prev_dout = 1'b0;

    pulse_edge_gen #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .PEND_W(PW)) dut (
        .clk(clk), .resetn(resetn), .pulse_in(pulse_in), .ovf_clr(ovf_clr),
        .dout(dout), .busy(busy), .pending(pending), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // A start at cycle s drives dout high for s+1..s+H and keeps busy for s+1..s+H+L;
    // the next start may happen no earlier than s+H+L.
    task automatic step(input logic p, input logic c, input logic r);
        int d;
        pulse_in = p;
        ovf_clr  = c;
        resetn   = r;
        if (!r) begin
            ls = -1000;
            q  = 0;
            ov = 0;
        end else if (cyc >= ls + H + L && (q > 0 || p)) begin
            if (q > 0 && !p) q--;
            ls = cyc;
            if (c) ov = 0;
        end else if (p && q < PMAX) begin
            q++;
            if (c) ov = 0;
        end else if (p) begin
            ov = 1;
        end else if (c) begin
            ov = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        d = cyc - ls;
        check("dout", int'(dout), int'(d >= 1 && d <= H));
        check("busy", int'(busy), int'(d >= 1 && d <= H + L));
        check("pending", int'(pending), q);
        check("ovf", int'(ovf), ov);
        if (dout === 1'b1 && prev_dout === 1'b0) rises++;
        prev_dout = dout;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int r0;
        do_reset();
        step(1'b1, 1'b0, 1'b1);
        idle(8);
        do_reset();
        step(1'b1, 1'b0, 1'b1);
        idle(1);
        step(1'b1, 1'b0, 1'b1);
        idle(10);
        do_reset();
        r0 = rises;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
        check("ovf_set", int'(ovf), 1);
        idle(25);
        check("ovf_edges", rises - r0, 4);
        step(1'b0, 1'b1, 1'b1);
        check("ovf_clr", int'(ovf), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("ovf_set_wins", int'(ovf), 1);
        idle(25);
        do_reset();
        step(1'b1, 1'b0, 1'b1);
        idle(4);
        step(1'b1, 1'b0, 1'b1);
        idle(10);
        do_reset();
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        r0 = rises;
        idle(15);
        check("rst_no_edges", rises - r0, 0);
        for (int i = 0; i < 3000; i++) begin
            int dens;
            dens = ((i / 200) % 3 == 0) ? 70 : (((i / 200) % 3 == 1) ? 25 : 8);
            step(($urandom_range(99) < dens) ? 1'b1 : 1'b0,
                 ($urandom_range(99) < 5) ? 1'b1 : 1'b0,
                 ($urandom_range(999) < 5) ? 1'b0 : 1'b1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
